sram_controller: RTL and testbench
==================================

Name: sram_controller

Overview:
- Memory-side responder for the MEM-stage data interface of the pipelined ARM core.
- Accepts 32-bit word read/write requests from the MEM stage and serialises each one into two 16-bit accesses on an external asynchronous SRAM.
- Drops `ready` while an access is in flight so the hazard/freeze logic can stall the pipeline.

Parameters:
- BASE_ADDR, 1024: byte address that maps to SRAM halfword 0.
- WAIT_CYCLES, 2: clock cycles each 16-bit SRAM access is held (>=1).
- SRAM_ADDR_W, 18: SRAM halfword address width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- rd_en  input  1  MEM-stage read request.
- wr_en  input  1  MEM-stage write request.
- address  input  32  byte address, word-aligned (bits[1:0] ignored).
- write_data  input  32  store data.
- read_data  output  32  load data, registered.
- ready  output  1  1 = no access pending or access completing this cycle.
- sram_addr  output  SRAM_ADDR_W  halfword address to SRAM.
- sram_dq_out  output  16  data driven to SRAM.
- sram_dq_in  input  16  data returned from SRAM.
- sram_dq_oe  output  1  1 = controller drives the SRAM data bus.
- sram_we_n  output  1  SRAM write strobe, active-low.

Behaviour:
- Reset (rst=0, async), all values forced immediately:
  - state=IDLE, counter=0, read_data=0.
  - sram_we_n=1, sram_dq_oe=0, sram_addr=0, sram_dq_out=0.
  - An access interrupted by reset is abandoned; no completion is signalled.
- Address mapping:
  - word = (address - BASE_ADDR) >> 2, 32-bit unsigned subtract.
  - sram_addr = {word[SRAM_ADDR_W-2:0], half}; half=0 is bits[15:0], half=1 is bits[31:16].
  - Out-of-range addresses wrap modulo 2^SRAM_ADDR_W halfwords. No error is flagged.
- FSM states: IDLE, LOW, HIGH, DONE.
  - IDLE: if rd_en|wr_en, latch op/address/write_data into internal registers and go to LOW.
    - wr_en has priority when rd_en and wr_en are both 1.
  - LOW: half=0; stays WAIT_CYCLES cycles (counter 0..WAIT_CYCLES-1), then goes to HIGH.
  - HIGH: half=1; stays WAIT_CYCLES cycles, then goes to DONE.
  - DONE: exactly one cycle, then IDLE.
    - A new request is not accepted in DONE; the next one is sampled in IDLE on the following cycle.
- ready (combinational) = (state==DONE) | (state==IDLE & ~rd_en & ~wr_en).
- Latency: request first seen in IDLE at cycle 0 gives ready=0 for cycles 0..2*WAIT_CYCLES and ready=1 at cycle 2*WAIT_CYCLES+1 (cycle 5 for the default).
- Write access:
  - sram_we_n=0 and sram_dq_oe=1 throughout LOW and HIGH.
  - sram_dq_out = latched data[15:0] in LOW, data[31:16] in HIGH.
  - In IDLE and DONE: we_n=1, oe=0.
- Read access:
  - we_n=1, oe=0 throughout.
  - read_data[15:0] captured from sram_dq_in on the last LOW cycle; read_data[31:16] captured on the last HIGH cycle.
  - read_data holds its value until the next read completes; writes never alter it.
- Request deasserted or changed mid-access: ignored, because inputs are latched in IDLE. The latched access completes normally.
- Counter is SRAM wait-counter width ceil(log2(WAIT_CYCLES))+1 bits. It clears on every state change and never wraps inside a state.

Decomposition:
- State encodings (IDLE/LOW/HIGH/DONE, 2 bits) and BASE_ADDR default go in the shared defines file as constants.
- One natural sub-module: sram_wait_counter.
  - Ports: clk, rst, clear, en, done.
  - done asserts when count==WAIT_CYCLES-1.
- Latch registers reuse the existing 32-bit enable register.

Test Plan:
- Reset mid-write (rst low during HIGH) -> sram_we_n=1, sram_dq_oe=0, read_data=0 immediately; state IDLE; ready=1 after release with no request.
- Write 0xDEADBEEF to address 1024 -> LOW cycles: sram_addr=0, dq_out=0xBEEF; HIGH cycles: sram_addr=1, dq_out=0xDEAD; ready rises on cycle 5.
- Read address 1032 with SRAM model holding hw4=0x5678, hw5=0x1234 -> sram_addr 4 then 5; read_data=0x12345678 when ready=1 at cycle 5; value held afterwards.
- rd_en=wr_en=1 at address 1028 -> write performed (we_n low, addr 2/3); read_data unchanged.
- Request inputs toggled to a new address during LOW -> SRAM sees the original address; ready high exactly at cycle 5; new request taken only after DONE.
- Back-to-back reads held for 12 cycles -> ready pulses high on cycles 5 and 11 only; address 1024+4*2^17 wraps to sram_addr 0/1.

Source files
------------

// File: rtl/sram_controller_pkg.sv
// Shared constants and types for the MEM-stage SRAM controller.
package sram_controller_pkg;

  // Controller FSM states, 2-bit encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [31:0] BASE_ADDR_DEF   = 32'd1024;
  localparam int          WAIT_CYCLES_DEF = 2;
  localparam int          SRAM_ADDR_W_DEF = 18;

  // Word index relative to the SRAM window; unsigned subtract so
  // addresses below the base wrap instead of faulting.
  function automatic logic [31:0] word_index(input logic [31:0] addr,
                                             input logic [31:0] base);
    logic [31:0] diff;
    diff = addr - base;
    return {2'b00, diff[31:2]};
  endfunction

endpackage

// File: rtl/sram_controller_if.sv
// MEM-stage data request/response bundle.
// master = pipeline MEM stage, slave = memory controller.
interface sram_controller_if;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  modport master (
    output rd_en, wr_en, address, write_data,
    input  read_data, ready
  );

  modport slave (
    input  rd_en, wr_en, address, write_data,
    output read_data, ready
  );
endinterface

// File: rtl/sram_wait_counter.sv
// Per-halfword wait counter: counts cycles spent in one SRAM access.
module sram_wait_counter #(
  parameter int WAIT_CYCLES = 2,
  localparam int CW = $clog2(WAIT_CYCLES) + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic done
);

  logic [CW-1:0] cnt;

  // Count while enabled; clear wins so the count never runs past the last cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       cnt <= '0;
    else if (clear) cnt <= '0;
    else if (en)    cnt <= cnt + 1'b1;
  end

  assign done = (cnt == CW'(WAIT_CYCLES - 1));

endmodule

// File: rtl/sram_controller.sv
// MEM-stage memory responder: splits each 32-bit word access into two
// 16-bit accesses on an asynchronous SRAM, low half first.
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEF,
  parameter int          WAIT_CYCLES = WAIT_CYCLES_DEF,
  parameter int          SRAM_ADDR_W = SRAM_ADDR_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  sram_controller_if.slave       mem,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [15:0]            sram_dq_out,
  input  logic [15:0]            sram_dq_in,
  output logic                   sram_dq_oe,
  output logic                   sram_we_n
);

  state_t                 state;
  logic                   op_wr;
  logic [SRAM_ADDR_W-2:0] word_q;
  logic [31:0]            wdata_q;
  logic [31:0]            rdata_q;
  logic [31:0]            word_in;
  logic                   req;
  logic                   cnt_en;
  logic                   cnt_clr;
  logic                   cnt_done;
  logic                   unused_word;

  assign req         = mem.rd_en | mem.wr_en;
  assign word_in     = word_index(mem.address, BASE_ADDR);
  // Bits above the SRAM window are dropped: out-of-range addresses wrap.
  assign unused_word = ^word_in[31:SRAM_ADDR_W-1];

  // Counter runs only inside a halfword access and restarts on each state change.
  assign cnt_en  = (state == ST_LOW) || (state == ST_HIGH);
  assign cnt_clr = ~cnt_en | cnt_done;

  sram_wait_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait (
    .clk   (clk),
    .rst   (rst),
    .clear (cnt_clr),
    .en    (cnt_en),
    .done  (cnt_done)
  );

  // ready is combinational so the stall releases in the DONE cycle itself.
  assign mem.ready     = (state == ST_DONE) || ((state == ST_IDLE) && !req);
  assign mem.read_data = rdata_q;

  // Access FSM; SRAM pins are registered and set up on the transition into
  // each halfword so they are stable for the whole access window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      op_wr       <= 1'b0;
      word_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            // Latch the request; later input changes cannot disturb the access.
            // Write wins when both strobes are raised.
            state       <= ST_LOW;
            op_wr       <= mem.wr_en;
            word_q      <= word_in[SRAM_ADDR_W-2:0];
            wdata_q     <= mem.write_data;
            sram_addr   <= {word_in[SRAM_ADDR_W-2:0], 1'b0};
            sram_dq_out <= mem.write_data[15:0];
            sram_dq_oe  <= mem.wr_en;
            sram_we_n   <= ~mem.wr_en;
          end
        end
        ST_LOW: begin
          if (cnt_done) begin
            state       <= ST_HIGH;
            sram_addr   <= {word_q, 1'b1};
            sram_dq_out <= wdata_q[31:16];
            if (!op_wr) rdata_q[15:0] <= sram_dq_in;
          end
        end
        ST_HIGH: begin
          if (cnt_done) begin
            state      <= ST_DONE;
            sram_dq_oe <= 1'b0;
            sram_we_n  <= 1'b1;
            if (!op_wr) rdata_q[31:16] <= sram_dq_in;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller with a small behavioural SRAM.
// Cycle c of a scenario is sampled just after the c-th falling edge, the
// request being applied at the falling edge of cycle 0.
module tb_sram_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic [15:0] sram_dq_in;
  logic        sram_dq_oe;
  logic        sram_we_n;

  int checks = 0;
  int errors = 0;

  sram_controller_if mif ();

  sram_controller dut (
    .clk         (clk),
    .rst         (rst),
    .mem         (mif),
    .sram_addr   (sram_addr),
    .sram_dq_out (sram_dq_out),
    .sram_dq_in  (sram_dq_in),
    .sram_dq_oe  (sram_dq_oe),
    .sram_we_n   (sram_we_n)
  );

  always #5 clk = ~clk;

  // SRAM model: 16 halfwords, bench preload port has priority over DUT writes.
  logic [15:0] sram_mem [0:15];
  logic        pl_en = 1'b0;
  logic [3:0]  pl_addr = '0;
  logic [15:0] pl_data = '0;

  always @(posedge clk) begin
    if (pl_en)           sram_mem[pl_addr] = pl_data;
    else if (!sram_we_n) sram_mem[sram_addr[3:0]] = sram_dq_out;
  end

  assign sram_dq_in = sram_mem[sram_addr[3:0]];

  task automatic preload(input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic clear_req();
    mif.rd_en = 1'b0; mif.wr_en = 1'b0; mif.address = '0; mif.write_data = '0;
  endtask

  task automatic test_reset();
    clear_req();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) preload(4'(i), 16'h0000);
    #1;
    checks++; if (sram_we_n !== 1'b1) begin errors++; $display("FAIL reset we_n: got %b exp 1", sram_we_n); end
    checks++; if (sram_dq_oe !== 1'b0) begin errors++; $display("FAIL reset oe: got %b exp 0", sram_dq_oe); end
    checks++; if (sram_addr !== 18'd0) begin errors++; $display("FAIL reset addr: got %h exp 0", sram_addr); end
    checks++; if (sram_dq_out !== 16'h0) begin errors++; $display("FAIL reset dq_out: got %h exp 0", sram_dq_out); end
    checks++; if (mif.read_data !== 32'h0) begin errors++; $display("FAIL reset read_data: got %h exp 0", mif.read_data); end
    checks++; if (mif.ready !== 1'b1) begin errors++; $display("FAIL reset ready: got %b exp 1", mif.ready); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    checks++; if (mif.ready !== 1'b1) begin errors++; $display("FAIL reset release ready: got %b exp 1", mif.ready); end
  endtask

  task automatic test_write();
    logic        er, ewe, eoe;
    logic [17:0] ea;
    logic [15:0] ed;
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      if (c == 0) begin mif.wr_en = 1'b1; mif.address = 32'd1024; mif.write_data = 32'hDEADBEEF; end
      if (c == 1) clear_req();
      #1;
      er  = (c >= 5);
      ewe = !(c >= 1 && c <= 4);
      eoe = (c >= 1 && c <= 4);
      checks++; if (mif.ready !== er) begin errors++; $display("FAIL write c%0d ready: got %b exp %b", c, mif.ready, er); end
      checks++; if (sram_we_n !== ewe) begin errors++; $display("FAIL write c%0d we_n: got %b exp %b", c, sram_we_n, ewe); end
      checks++; if (sram_dq_oe !== eoe) begin errors++; $display("FAIL write c%0d oe: got %b exp %b", c, sram_dq_oe, eoe); end
      if (c >= 1 && c <= 4) begin
        ea = (c <= 2) ? 18'd0 : 18'd1;
        ed = (c <= 2) ? 16'hBEEF : 16'hDEAD;
        checks++; if (sram_addr !== ea) begin errors++; $display("FAIL write c%0d addr: got %h exp %h", c, sram_addr, ea); end
        checks++; if (sram_dq_out !== ed) begin errors++; $display("FAIL write c%0d dq_out: got %h exp %h", c, sram_dq_out, ed); end
      end
    end
    checks++; if (sram_mem[0] !== 16'hBEEF) begin errors++; $display("FAIL write mem0: got %h exp beef", sram_mem[0]); end
    checks++; if (sram_mem[1] !== 16'hDEAD) begin errors++; $display("FAIL write mem1: got %h exp dead", sram_mem[1]); end
    checks++; if (mif.read_data !== 32'h0) begin errors++; $display("FAIL write read_data: got %h exp 0", mif.read_data); end
  endtask

  task automatic test_read();
    logic        er;
    logic [17:0] ea;
    preload(4'd4, 16'h5678);
    preload(4'd5, 16'h1234);
    for (int c = 0; c <= 7; c++) begin
      @(negedge clk);
      if (c == 0) begin mif.rd_en = 1'b1; mif.address = 32'd1032; end
      if (c == 1) clear_req();
      #1;
      er = (c >= 5);
      checks++; if (mif.ready !== er) begin errors++; $display("FAIL read c%0d ready: got %b exp %b", c, mif.ready, er); end
      checks++; if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0) begin
        errors++; $display("FAIL read c%0d strobes: got we_n=%b oe=%b exp we_n=1 oe=0", c, sram_we_n, sram_dq_oe); end
      if (c >= 1 && c <= 4) begin
        ea = (c <= 2) ? 18'd4 : 18'd5;
        checks++; if (sram_addr !== ea) begin errors++; $display("FAIL read c%0d addr: got %h exp %h", c, sram_addr, ea); end
      end
      if (c == 3) begin
        checks++; if (mif.read_data !== 32'h00005678) begin errors++; $display("FAIL read low capture: got %h exp 00005678", mif.read_data); end
      end
      if (c >= 5) begin
        checks++; if (mif.read_data !== 32'h12345678) begin errors++; $display("FAIL read c%0d data: got %h exp 12345678", c, mif.read_data); end
      end
    end
  endtask

  task automatic test_both();
    logic        ewe;
    logic [17:0] ea;
    logic [15:0] ed;
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      if (c == 0) begin mif.rd_en = 1'b1; mif.wr_en = 1'b1; mif.address = 32'd1028; mif.write_data = 32'hCAFEF00D; end
      if (c == 1) clear_req();
      #1;
      ewe = !(c >= 1 && c <= 4);
      checks++; if (sram_we_n !== ewe) begin errors++; $display("FAIL both c%0d we_n: got %b exp %b", c, sram_we_n, ewe); end
      if (c >= 1 && c <= 4) begin
        ea = (c <= 2) ? 18'd2 : 18'd3;
        ed = (c <= 2) ? 16'hF00D : 16'hCAFE;
        checks++; if (sram_addr !== ea) begin errors++; $display("FAIL both c%0d addr: got %h exp %h", c, sram_addr, ea); end
        checks++; if (sram_dq_out !== ed) begin errors++; $display("FAIL both c%0d dq_out: got %h exp %h", c, sram_dq_out, ed); end
      end
      if (c == 5) begin
        checks++; if (mif.ready !== 1'b1) begin errors++; $display("FAIL both ready: got %b exp 1", mif.ready); end
        checks++; if (mif.read_data !== 32'h12345678) begin errors++; $display("FAIL both read_data: got %h exp 12345678", mif.read_data); end
      end
    end
    checks++; if (sram_mem[2] !== 16'hF00D || sram_mem[3] !== 16'hCAFE) begin
      errors++; $display("FAIL both mem: got %h %h exp f00d cafe", sram_mem[2], sram_mem[3]); end
  endtask

  task automatic test_change();
    logic        er;
    logic [17:0] ea;
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      if (c == 0) begin mif.rd_en = 1'b1; mif.address = 32'd1024; end
      if (c == 1) begin mif.address = 32'd1036; mif.wr_en = 1'b0; end
      if (c == 7) clear_req();
      #1;
      er = (c == 5 || c == 11 || c == 12);
      checks++; if (mif.ready !== er) begin errors++; $display("FAIL change c%0d ready: got %b exp %b", c, mif.ready, er); end
      if ((c >= 1 && c <= 4) || (c >= 7 && c <= 10)) begin
        case (c)
          1, 2:    ea = 18'd0;
          3, 4:    ea = 18'd1;
          7, 8:    ea = 18'd6;
          default: ea = 18'd7;
        endcase
        checks++; if (sram_addr !== ea) begin errors++; $display("FAIL change c%0d addr: got %h exp %h", c, sram_addr, ea); end
      end
      if (c == 5) begin
        checks++; if (mif.read_data !== 32'hDEADBEEF) begin errors++; $display("FAIL change read_data: got %h exp deadbeef", mif.read_data); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic        er;
    logic [17:0] ea;
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      if (c == 0) begin mif.rd_en = 1'b1; mif.address = 32'd1024 + 32'd4 * (32'd1 << 17); end
      if (c == 12) clear_req();
      #1;
      er = (c == 5 || c == 11 || c == 12);
      checks++; if (mif.ready !== er) begin errors++; $display("FAIL b2b c%0d ready: got %b exp %b", c, mif.ready, er); end
      if (c == 1 || c == 3 || c == 7 || c == 9) begin
        ea = (c == 1 || c == 7) ? 18'd0 : 18'd1;
        checks++; if (sram_addr !== ea) begin errors++; $display("FAIL b2b c%0d addr: got %h exp %h", c, sram_addr, ea); end
      end
      if (c == 4) begin
        checks++; if (mif.read_data !== 32'h0000BEEF) begin errors++; $display("FAIL b2b low capture: got %h exp 0000beef", mif.read_data); end
      end
      if (c == 5 || c == 11) begin
        checks++; if (mif.read_data !== 32'hDEADBEEF) begin errors++; $display("FAIL b2b c%0d data: got %h exp deadbeef", c, mif.read_data); end
      end
    end
  endtask

  task automatic test_reset_mid_write();
    for (int c = 0; c <= 3; c++) begin
      @(negedge clk);
      if (c == 0) begin mif.wr_en = 1'b1; mif.address = 32'd1028; mif.write_data = 32'h0BADF00D; end
      if (c == 1) clear_req();
    end
    #1;
    checks++; if (sram_we_n !== 1'b0 || sram_addr !== 18'd3) begin
      errors++; $display("FAIL rstw high phase: got we_n=%b addr=%h exp we_n=0 addr=3", sram_we_n, sram_addr); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (sram_we_n !== 1'b1) begin errors++; $display("FAIL rstw we_n: got %b exp 1", sram_we_n); end
    checks++; if (sram_dq_oe !== 1'b0) begin errors++; $display("FAIL rstw oe: got %b exp 0", sram_dq_oe); end
    checks++; if (mif.read_data !== 32'h0) begin errors++; $display("FAIL rstw read_data: got %h exp 0", mif.read_data); end
    checks++; if (sram_addr !== 18'd0 || sram_dq_out !== 16'h0) begin
      errors++; $display("FAIL rstw bus: got addr=%h dq=%h exp 0 0", sram_addr, sram_dq_out); end
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); #1;
      checks++; if (mif.ready !== 1'b1 || sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0) begin
        errors++; $display("FAIL rstw after c%0d: got ready=%b we_n=%b oe=%b exp 1 1 0", c, mif.ready, sram_we_n, sram_dq_oe); end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_both();
    test_change();
    test_back_to_back();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
